// File: rtl/sha2_round_engine.sv
// Iterative SHA-2 compression round engine: one round per cycle with valid K+W,
// then an optional feed-forward add of the initial hash state into the digest.
module sha2_round_engine #(
   parameter int unsigned WORD_W   = 32,
   parameter int unsigned ROUNDS   = 64,
   parameter int unsigned FEED_FWD = 1,
   parameter int unsigned RIDX_W   = 7
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [8*WORD_W-1:0]   init_state,
   input  logic [WORD_W-1:0]     kw_in,
   input  logic                  kw_valid,
   output logic [RIDX_W-1:0]     round_idx,
   output logic                  busy,
   output logic                  done,
   output logic [8*WORD_W-1:0]   digest
);

   // Rotation amounts of the big-sigma functions for the two SHA-2 word widths
   localparam int unsigned S0_R0 = (WORD_W == 64) ? 28 : 2;
   localparam int unsigned S0_R1 = (WORD_W == 64) ? 34 : 13;
   localparam int unsigned S0_R2 = (WORD_W == 64) ? 39 : 22;
   localparam int unsigned S1_R0 = (WORD_W == 64) ? 14 : 6;
   localparam int unsigned S1_R1 = (WORD_W == 64) ? 18 : 11;
   localparam int unsigned S1_R2 = (WORD_W == 64) ? 41 : 25;

   localparam logic [RIDX_W-1:0] LAST_ROUND = RIDX_W'(ROUNDS - 1);

   typedef enum logic [1:0] {StIdle, StRun, StAdd, StDone} state_e;

   typedef logic [7:0][WORD_W-1:0] words_t;

   function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x,
                                              input int unsigned n);
      return (x >> n) | (x << (WORD_W - n));
   endfunction

   state_e              state_q, state_d;
   words_t              work_q, work_d;
   words_t              init_q, init_d;
   words_t              round_res;
   words_t              sum_res;
   logic [RIDX_W-1:0]   ridx_q, ridx_d;
   logic [8*WORD_W-1:0] digest_q, digest_d;

   // Working variables; word 7 is a (MSBs), word 0 is h
   logic [WORD_W-1:0] wa, wb, wc, wd, we, wf, wg, wh;
   logic [WORD_W-1:0] sig0, sig1, ch, maj, t1, t2;

   assign wa = work_q[7];
   assign wb = work_q[6];
   assign wc = work_q[5];
   assign wd = work_q[4];
   assign we = work_q[3];
   assign wf = work_q[2];
   assign wg = work_q[1];
   assign wh = work_q[0];

   // One compression round on the current working state
   always_comb begin
      sig0 = rotr(wa, S0_R0) ^ rotr(wa, S0_R1) ^ rotr(wa, S0_R2);
      sig1 = rotr(we, S1_R0) ^ rotr(we, S1_R1) ^ rotr(we, S1_R2);
      ch   = (we & wf) ^ (~we & wg);
      maj  = (wa & wb) ^ (wa & wc) ^ (wb & wc);
      t1   = wh + sig1 + ch + kw_in;
      t2   = sig0 + maj;
      round_res[7] = t1 + t2;
      round_res[6] = wa;
      round_res[5] = wb;
      round_res[4] = wc;
      round_res[3] = wd + t1;
      round_res[2] = we;
      round_res[1] = wf;
      round_res[0] = wg;
   end

   // Word-wise feed-forward sum of final and initial state
   always_comb begin
      sum_res = '0;
      for (int i = 0; i < 8; i++) begin
         sum_res[i] = work_q[i] + init_q[i];
      end
   end

   // Next-state logic for the control FSM and datapath registers
   always_comb begin
      state_d  = state_q;
      work_d   = work_q;
      init_d   = init_q;
      ridx_d   = ridx_q;
      digest_d = digest_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               work_d  = init_state;
               init_d  = init_state;
               ridx_d  = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            if (kw_valid) begin
               work_d = round_res;
               if (ridx_q == LAST_ROUND) begin
                  ridx_d  = '0;
                  state_d = StAdd;
               end else begin
                  ridx_d = ridx_q + 1'b1;
               end
            end
         end
         StAdd: begin
            digest_d = (FEED_FWD != 0) ? sum_res : work_q;
            state_d  = StDone;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and datapath registers; reset discards any partial block
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         work_q   <= '0;
         init_q   <= '0;
         ridx_q   <= '0;
         digest_q <= '0;
      end else begin
         state_q  <= state_d;
         work_q   <= work_d;
         init_q   <= init_d;
         ridx_q   <= ridx_d;
         digest_q <= digest_d;
      end
   end

   assign round_idx = ridx_q;
   assign busy      = (state_q == StRun) || (state_q == StAdd);
   assign done      = (state_q == StDone);
   assign digest    = digest_q;

endmodule

// File: tb/tb_sha2_round_engine.sv
// Directed bench for sha2_round_engine: single-round vectors, SHA-256 "abc",
// stalls, start handling and asynchronous reset mid-block.
module tb_sha2_round_engine;

   localparam logic [255:0] H0 =
      256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
   localparam logic [255:0] ABC_DIGEST =
      256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

   localparam logic [31:0] K_TAB [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   logic clk;
   logic rst_n;

   // dut_a: WORD_W=32, ROUNDS=1, FEED_FWD=0
   logic          start_a, kv_a, busy_a, done_a;
   logic [255:0]  init_a, dig_a;
   logic [31:0]   kw_a;
   logic [6:0]    ridx_a;

   // dut_b: WORD_W=64, ROUNDS=1, FEED_FWD=1
   logic          start_b, kv_b, busy_b, done_b;
   logic [511:0]  init_b, dig_b;
   logic [63:0]   kw_b;
   logic [6:0]    ridx_b;

   // dut_c: SHA-256 defaults
   logic          start_c, kv_c, busy_c, done_c;
   logic [255:0]  init_c, dig_c;
   logic [31:0]   kw_c;
   logic [6:0]    ridx_c;

   logic [31:0]   kw_tab [64];
   int            n_checks;
   int            n_errors;

   sha2_round_engine #(.WORD_W(32), .ROUNDS(1), .FEED_FWD(0), .RIDX_W(7)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .init_state(init_a), .kw_in(kw_a),
      .kw_valid(kv_a), .round_idx(ridx_a), .busy(busy_a), .done(done_a), .digest(dig_a)
   );

   sha2_round_engine #(.WORD_W(64), .ROUNDS(1), .FEED_FWD(1), .RIDX_W(7)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .init_state(init_b), .kw_in(kw_b),
      .kw_valid(kv_b), .round_idx(ridx_b), .busy(busy_b), .done(done_b), .digest(dig_b)
   );

   sha2_round_engine #(.WORD_W(32), .ROUNDS(64), .FEED_FWD(1), .RIDX_W(7)) dut_c (
      .clk(clk), .rst_n(rst_n), .start(start_c), .init_state(init_c), .kw_in(kw_c),
      .kw_valid(kv_c), .round_idx(ridx_c), .busy(busy_c), .done(done_c), .digest(dig_c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] rr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // K[t]+W[t] for the padded one-block message "abc"
   task automatic build_kw();
      logic [31:0] w [64];
      logic [31:0] s0, s1;
      for (int t = 0; t < 16; t++) w[t] = 32'h0;
      w[0]  = 32'h61626380;
      w[15] = 32'h00000018;
      for (int t = 16; t < 64; t++) begin
         s0 = rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3);
         s1 = rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10);
         w[t] = s1 + w[t-7] + s0 + w[t-16];
      end
      for (int t = 0; t < 64; t++) kw_tab[t] = K_TAB[t] + w[t];
   endtask

   // One "abc" block on dut_c; optional stalls and ignored start pulses
   task automatic run_abc(input bit stall, input bit poke, input logic [255:0] hold,
                          output int lat, output int nst);
      int t;
      int cyc;
      t = 0;
      nst = 0;
      init_c = H0;
      start_c = 1'b1;
      kv_c = 1'b1;
      kw_c = kw_tab[0];
      @(posedge clk); #1;
      start_c = 1'b0;
      cyc = 1;
      check("busy_after_start", 512'(busy_c), 512'(1));
      while (!done_c && cyc < 400) begin
         if (cyc == 10) check("digest_hold_run", 512'(dig_c), 512'(hold));
         start_c = (poke && cyc == 5);
         if (t < 64) begin
            if (stall && (cyc % 3 == 2)) begin
               kv_c = 1'b0;
               kw_c = $urandom;
               nst++;
               check("ridx_stall", 512'(ridx_c), 512'(t));
            end else begin
               kv_c = 1'b1;
               kw_c = kw_tab[t];
            end
         end else begin
            kv_c = 1'b0;
         end
         @(posedge clk); #1;
         cyc++;
         if (kv_c && t < 64) t++;
      end
      start_c = 1'b0;
      kv_c = 1'b0;
      lat = cyc;
      check("done_seen", 512'(done_c), 512'(1));
      if (poke) begin
         start_c = 1'b1;
         @(posedge clk); #1;
         start_c = 1'b0;
         check("idle_after_done", 512'(busy_c), 512'(0));
      end
   endtask

   initial begin
      int cyc;
      int lat;
      int nst;
      int t;
      int spur;
      n_checks = 0;
      n_errors = 0;
      rst_n = 1'b0;
      start_a = 1'b0; kv_a = 1'b0; init_a = '0; kw_a = '0;
      start_b = 1'b0; kv_b = 1'b0; init_b = '0; kw_b = '0;
      start_c = 1'b0; kv_c = 1'b0; init_c = '0; kw_c = '0;
      build_kw();
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 512'(busy_c), 512'(0));
      check("rst_done", 512'(done_c), 512'(0));
      check("rst_ridx", 512'(ridx_c), 512'(0));
      check("rst_digest", 512'(dig_c), 512'(0));
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Single round exercising Maj and big-sigma0
      init_a = {32'hAAAAAAAA, 32'h55555555, 32'hF0F0F0F0, 160'h0};
      kw_a = 32'h0;
      kv_a = 1'b1;
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      cyc = 1;
      while (!done_a && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("a_latency", 512'(cyc), 512'(3));
      check("a_digest", 512'(dig_a),
            512'({32'h46464645, 32'hAAAAAAAA, 32'h55555555, 32'hF0F0F0F0, 128'h0}));
      check("a_ridx_wrap", 512'(ridx_a), 512'(0));
      check("a_busy_done", 512'(busy_a), 512'(0));
      kv_a = 1'b0;

      // Zero state, 64-bit words, feed-forward on
      init_b = '0;
      kw_b = 64'd1;
      kv_b = 1'b1;
      start_b = 1'b1;
      @(posedge clk); #1;
      start_b = 1'b0;
      cyc = 1;
      while (!done_b && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("b_latency", 512'(cyc), 512'(3));
      check("b_digest", dig_b, {64'd1, 192'd0, 64'd1, 192'd0});
      check("b_ridx_wrap", 512'(ridx_b), 512'(0));
      check("b_busy_done", 512'(busy_b), 512'(0));
      kv_b = 1'b0;
      @(posedge clk); #1;

      // Full SHA-256 "abc"
      run_abc(1'b0, 1'b0, 256'h0, lat, nst);
      check("abc_latency", 512'(lat), 512'(66));
      check("abc_digest", 512'(dig_c), 512'(ABC_DIGEST));
      @(posedge clk); #1;

      // Same block with kw_valid low every third cycle
      run_abc(1'b1, 1'b0, ABC_DIGEST, lat, nst);
      check("stall_count", 512'(nst > 0), 512'(1));
      check("stall_latency", 512'(lat), 512'(66 + nst));
      check("stall_digest", 512'(dig_c), 512'(ABC_DIGEST));
      @(posedge clk); #1;

      // Starts during RUN and in the done cycle are ignored, then back-to-back block
      run_abc(1'b0, 1'b1, ABC_DIGEST, lat, nst);
      check("poke_latency", 512'(lat), 512'(66));
      check("poke_digest", 512'(dig_c), 512'(ABC_DIGEST));
      run_abc(1'b0, 1'b0, ABC_DIGEST, lat, nst);
      check("b2b_latency", 512'(lat), 512'(66));
      check("b2b_digest", 512'(dig_c), 512'(ABC_DIGEST));
      @(posedge clk); #1;

      // Asynchronous reset at round 10 of a block
      init_c = H0;
      start_c = 1'b1;
      kv_c = 1'b1;
      kw_c = kw_tab[0];
      t = 0;
      @(posedge clk); #1;
      start_c = 1'b0;
      cyc = 1;
      while (t < 10 && cyc < 40) begin
         kw_c = kw_tab[t];
         @(posedge clk); #1;
         cyc++;
         t++;
      end
      check("mid_ridx_before_rst", 512'(ridx_c), 512'(10));
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", 512'(busy_c), 512'(0));
      check("mid_rst_done", 512'(done_c), 512'(0));
      check("mid_rst_ridx", 512'(ridx_c), 512'(0));
      check("mid_rst_digest", 512'(dig_c), 512'(0));
      @(posedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
      spur = 0;
      repeat (68) begin
         @(posedge clk); #1;
         if (done_c || busy_c) spur++;
      end
      check("no_spurious_done", 512'(spur), 512'(0));
      kv_c = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
